// File: rtl/btn_click_decoder_if.sv
// Event handshake between the click decoder and whatever consumes its events.
//   evt_valid : head of the event FIFO holds an event
//   evt_code  : 1 = single, 2 = double, 3 = triple click; 0 when empty
//   evt_ready : consumer takes the head event when evt_valid && evt_ready
// master = decoder side, slave = consumer side.
interface btn_click_decoder_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/btn_click_decoder.sv
// Groups debounced button presses into single/double/triple click events and
// queues them in a 4-entry FIFO for a ready/valid consumer.
//   clk            : single clock, all logic on its rising edge
//   rst_n          : synchronous active-low reset
//   btn_n          : debounced button, low pulse per accepted press
//   evt            : event handshake (master side)
//   clicks_pending : clicks counted so far in the open group
//   ovf            : sticky, an event was dropped because the FIFO was full
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no open group, waiting for the first press
// ST_COUNT | group open, counting presses and idle cycles since last
module btn_click_decoder #(
  parameter logic [25:0] CLICK_WIN  = 26'd13_500_000,
  parameter int unsigned MAX_CLICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_n,
  btn_click_decoder_if.master   evt,
  output logic [1:0]            clicks_pending,
  output logic                  ovf
);

  localparam logic [25:0] WIN_LAST = CLICK_WIN - 26'd1;
  localparam logic [1:0]  MAX_CODE = 2'(MAX_CLICKS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  count, count_nxt;
  logic [25:0] timer, timer_nxt;
  logic        btn_q;
  logic        press;
  logic [1:0]  press_count;
  logic        push;
  logic [1:0]  push_code;

  // A held-low input produces only one press: it needs the previous cycle high.
  assign press = !btn_n && btn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= 1'b1;
      state <= ST_IDLE;
      count <= 2'd0;
      timer <= 26'd0;
    end else begin
      btn_q <= btn_n;
      state <= state_nxt;
      count <= count_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    timer_nxt   = timer;
    push        = 1'b0;
    push_code   = 2'd0;
    // Count the group would reach if this cycle's press joins it.
    press_count = (state == ST_IDLE) ? 2'd1 : count + 2'd1;

    case (state)
      ST_IDLE: begin
        if (press) begin
          if (press_count == MAX_CODE) begin
            // MAX_CLICKS == 1: every press is a complete group.
            push      = 1'b1;
            push_code = MAX_CODE;
            count_nxt = 2'd0;
            timer_nxt = 26'd0;
          end else begin
            state_nxt = ST_COUNT;
            count_nxt = press_count;
            timer_nxt = 26'd0;
          end
        end
      end
      ST_COUNT: begin
        // A press wins over window expiry, so a press on the last window
        // cycle still joins the group.
        if (press) begin
          timer_nxt = 26'd0;
          if (press_count == MAX_CODE) begin
            push      = 1'b1;
            push_code = MAX_CODE;
            count_nxt = 2'd0;
            state_nxt = ST_IDLE;
          end else begin
            count_nxt = press_count;
          end
        end else if (timer == WIN_LAST) begin
          push      = 1'b1;
          push_code = count;
          count_nxt = 2'd0;
          timer_nxt = 26'd0;
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer + 26'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = 2'd0;
        timer_nxt = 26'd0;
      end
    endcase
  end

  assign clicks_pending = count;

  // Event FIFO
  logic [1:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] occ;
  logic       fifo_full;
  logic       pop;
  logic       do_write;

  assign fifo_full = (occ == 3'd4);
  assign pop       = evt.evt_valid && evt.evt_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_write  = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
      ovf    <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 2'd1;
      if (pop)      rd_ptr <= rd_ptr + 2'd1;
      case ({do_write, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
      if (push && !do_write) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked until occupancy says it is valid.
  always_ff @(posedge clk) begin
    if (do_write) fifo_mem[wr_ptr] <= push_code;
  end

  assign evt.evt_valid = (occ != 3'd0);
  assign evt.evt_code  = evt.evt_valid ? fifo_mem[rd_ptr] : 2'd0;

endmodule
